beacon_rx_parser: RTL
=====================

// Module: beacon_rx_parser
// PURPOSE
//  Upstream stage of learnCosts. Takes the received beacon byte stream from the radio RX FIFO and checks
//  type, destination, self-echo, length and checksum. Latches the 16-bit fsourceID/fbatteryStat/fValue/
//  fclusterID fields and pulses lc_en for one cycle, then holds the fields stable until learnCosts
//  asserts done. Rejected packets are dropped and counted.
// PARAMETERS
//  BEACON_TYPE   8'hB1  required value of byte 0
//  BCAST_ID      16'hFFFF destination ID accepted in addition to own_id
//  TIMEOUT_CYC   1024   max cycles in WAIT_DONE before abandoning the handshake
// PORTS
//  clock        in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  own_id       in   16  this node's ID (static)
//  rx_valid     in   1   rx_byte valid this cycle
//  rx_byte      in   8   packet byte, big-endian fields
//  rx_last      in   1   qualifies final byte of packet (valid only with rx_valid)
//  rx_ready     out  1   parser accepts a byte when rx_valid&rx_ready
//  fsourceID    out  16  latched source ID
//  fbatteryStat out  16  latched battery status
//  fValue       out  16  latched cost value
//  fclusterID   out  16  latched cluster ID
//  lc_en        out  1   one-cycle start pulse to learnCosts
//  lc_done      in   1   learnCosts done
//  drop_cnt     out  8   saturating count of rejected packets
//  timeout      out  1   one-cycle pulse when WAIT_DONE expires
//  state_out    out  3   current FSM state encoding (debug)
// BEHAVIOUR
//  Frame (12 B): [0]type [1:2]dest [3:4]src [5:6]batt [7:8]value [9:10]cluster [11]chk; chk = XOR of bytes 0..10.
//  Reset: all outputs 0, state IDLE, drop_cnt 0; rx_ready=0 in reset, 1 first cycle after.
//  States: IDLE=0 RECV=1 ISSUE=2 WAIT_DONE=3 DRAIN=4.
//  IDLE: rx_ready=1. Accepted byte becomes byte 0 -> RECV (bad type -> DRAIN, or drop immediately if rx_last).
//  RECV: 4-bit byte index; running XOR; fields assembled in shadow regs, not visible on outputs.
//   - after byte 2: dest != own_id and != BCAST_ID -> error.
//   - after byte 4: src == own_id -> error (self echo).
//   - rx_last before byte 11 -> drop, IDLE. Byte 11 without rx_last -> error.
//   - byte 11 with rx_last: chk match -> ISSUE; mismatch -> drop, IDLE.
//   - error mid-packet -> DRAIN.
//  DRAIN: rx_ready=1, discard bytes until accepted byte has rx_last -> IDLE; drop counted once per packet.
//  ISSUE: one cycle; output field regs loaded from shadow, lc_en=1; rx_ready=0 -> WAIT_DONE.
//   lc_en asserts in cycle after byte 11 accepted (latency 1); fields valid in same cycle as lc_en.
//  WAIT_DONE: rx_ready=0; lc_done=1 -> IDLE next cycle. Counter reaching TIMEOUT_CYC -> timeout pulse, IDLE.
//   lc_done seen outside WAIT_DONE ignored. Fields stay held until next ISSUE.
//  drop_cnt saturates at 255; increments exactly once per rejected packet.
//  rx_valid=0 mid-packet: stall, no timeout in RECV/DRAIN.
//  rst mid-packet: abort immediately, fields and drop_cnt cleared, no lc_en.
// TESTING
//  1 Valid beacon B1 FFFF 0001 0005 000A 000B chk, own_id=001F -> lc_en 1 cycle; fields 1/5/10/11; drop_cnt 0.
//  2 Same frame with dest=0030 -> no lc_en; bytes drained to rx_last; drop_cnt=1; fields unchanged.
//  3 Corrupt chk byte (XOR^01) -> no lc_en; drop_cnt+1. Frame src=001F -> dropped as echo.
//  4 Valid beacon, hold lc_done=0 for TIMEOUT_CYC cycles -> timeout pulse, IDLE, rx_ready=1.
//   Second run: lc_done after 20 cycles -> IDLE; rx_ready=0 for whole WAIT_DONE.
//  5 8-byte frame with rx_last on byte 7 -> dropped; 14-byte frame -> drain to rx_last, dropped.
//   Next valid frame accepted normally.
//  6 Assert rst at byte 6 of valid frame -> all outputs 0, no lc_en; 300 bad frames -> drop_cnt holds 255.

Source files
------------

// File: rtl/beacon_rx_parser.sv
// Beacon frame parser in front of learnCosts: validates type, destination, echo, length and checksum,
// then hands the latched fields over with a one-cycle lc_en and waits for lc_done.
module beacon_rx_parser #(
  parameter logic [7:0]  BEACON_TYPE = 8'hB1,
  parameter logic [15:0] BCAST_ID    = 16'hFFFF,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [15:0] own_id,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_last,
  output logic        rx_ready,
  output logic [15:0] fsourceID,
  output logic [15:0] fbatteryStat,
  output logic [15:0] fValue,
  output logic [15:0] fclusterID,
  output logic        lc_en,
  input  logic        lc_done,
  output logic [7:0]  drop_cnt,
  output logic        timeout,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RECV      = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_r, state_nxt;
  logic [3:0]        idx_r;
  logic [7:0]        chk_r;
  logic [7:0]        dest_hi_r;
  logic [15:0]       src_r, batt_r, value_r, cluster_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              rx_ready_r, lc_en_r, timeout_r;
  logic [7:0]        drop_cnt_r;
  logic [15:0]       fsrc_r, fbatt_r, fval_r, fclu_r;
  logic              accept_s, dest_err_s, echo_err_s, drop_s, timeout_s;

  assign accept_s   = rx_valid & rx_ready_r;
  assign dest_err_s = (idx_r == 4'd2) && ({dest_hi_r, rx_byte} != own_id) && ({dest_hi_r, rx_byte} != BCAST_ID);
  assign echo_err_s = (idx_r == 4'd4) && ({src_r[15:8], rx_byte} == own_id);

  // Next-state decode plus drop/timeout strobes
  always_comb begin
    state_nxt = state_r;
    drop_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (rx_last) begin
            drop_s = 1'b1;
          end else if (rx_byte != BEACON_TYPE) begin
            state_nxt = DRAIN;
            drop_s    = 1'b1;
          end else begin
            state_nxt = RECV;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RECV: begin
        if (accept_s) begin
          if (idx_r == 4'd11) begin
            if (!rx_last) begin
              state_nxt = DRAIN;
              drop_s    = 1'b1;
            end else if (chk_r == rx_byte) begin
              state_nxt = ISSUE;
            end else begin
              state_nxt = IDLE;
              drop_s    = 1'b1;
            end
          end else if (rx_last) begin
            state_nxt = IDLE;
            drop_s    = 1'b1;
          end else if (dest_err_s || echo_err_s) begin
            state_nxt = DRAIN;
            drop_s    = 1'b1;
          end else begin
            state_nxt = RECV;
          end
        end else begin
          state_nxt = RECV;
        end
      end
      ISSUE: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (lc_done) begin
          state_nxt = IDLE;
        end else if (wait_cnt_r == CNT_LAST) begin
          state_nxt = IDLE;
          timeout_s = 1'b1;
        end else begin
          state_nxt = WAIT_DONE;
        end
      end
      DRAIN: begin
        if (accept_s && rx_last) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, shadow assembly, output latching and counters
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= 4'd0;
      chk_r      <= 8'h00;
      dest_hi_r  <= 8'h00;
      src_r      <= 16'h0000;
      batt_r     <= 16'h0000;
      value_r    <= 16'h0000;
      cluster_r  <= 16'h0000;
      wait_cnt_r <= '0;
      rx_ready_r <= 1'b0;
      lc_en_r    <= 1'b0;
      timeout_r  <= 1'b0;
      drop_cnt_r <= 8'h00;
      fsrc_r     <= 16'h0000;
      fbatt_r    <= 16'h0000;
      fval_r     <= 16'h0000;
      fclu_r     <= 16'h0000;
    end else begin
      state_r    <= state_nxt;
      rx_ready_r <= (state_nxt == IDLE) || (state_nxt == RECV) || (state_nxt == DRAIN);
      lc_en_r    <= (state_nxt == ISSUE);
      timeout_r  <= timeout_s;
      wait_cnt_r <= (state_r == WAIT_DONE) ? (wait_cnt_r + CNT_ONE) : '0;
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
      if (accept_s && (state_r == IDLE)) begin
        idx_r <= 4'd1;
        chk_r <= rx_byte;
      end else if (accept_s && (state_r == RECV)) begin
        idx_r <= idx_r + 4'd1;
        chk_r <= chk_r ^ rx_byte;
        case (idx_r)
          4'd1:    dest_hi_r       <= rx_byte;
          4'd3:    src_r[15:8]     <= rx_byte;
          4'd4:    src_r[7:0]      <= rx_byte;
          4'd5:    batt_r[15:8]    <= rx_byte;
          4'd6:    batt_r[7:0]     <= rx_byte;
          4'd7:    value_r[15:8]   <= rx_byte;
          4'd8:    value_r[7:0]    <= rx_byte;
          4'd9:    cluster_r[15:8] <= rx_byte;
          4'd10:   cluster_r[7:0]  <= rx_byte;
          default: ;
        endcase
      end
      // Fields only become visible together with the lc_en pulse
      if (state_nxt == ISSUE) begin
        fsrc_r  <= src_r;
        fbatt_r <= batt_r;
        fval_r  <= value_r;
        fclu_r  <= cluster_r;
      end
    end
  end

  assign rx_ready     = rx_ready_r;
  assign lc_en        = lc_en_r;
  assign timeout      = timeout_r;
  assign drop_cnt     = drop_cnt_r;
  assign fsourceID    = fsrc_r;
  assign fbatteryStat = fbatt_r;
  assign fValue       = fval_r;
  assign fclusterID   = fclu_r;
  assign state_out    = state_r;

endmodule
